// File: rtl/pistorm_bus_arbiter.sv
// 68000 bus-mastership arbiter between the Pi transaction engine and ST DMA masters.
// Optional macro ARB_FAIR_EN: after a DMA tenure the Pi gets one bus cycle before BR is honoured again.
`timescale 1ns/100ps

module pistorm_bus_arbiter #(
  parameter int BG_TIMEOUT_CYC = 16,
  parameter int REARB_GAP_CYC  = 2,
  parameter int CNT_W          = 16
) (
  input  logic             PI_CLK,
  input  logic             SYS_RESET_n,
  input  logic             M68K_CLK,
  input  logic             M68K_BR_n,
  input  logic             M68K_BGACK_n,
  input  logic             M68K_AS_n,
  input  logic             TXN_REQ,
  input  logic             TXN_ACTIVE,
  input  logic             TXN_DONE,
  output logic             BUS_GRANT_PI,
  output logic             M68K_BG_n,
  output logic [2:0]       ARB_STATE,
  output logic [CNT_W-1:0] DMA_COUNT
);

  localparam int TO_W  = $clog2(BG_TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(REARB_GAP_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(BG_TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(REARB_GAP_CYC);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PEND    = 3'd1,
    ST_GRANT   = 3'd2,
    ST_OWNED   = 3'd3,
    ST_RECOVER = 3'd4
  } arb_state_t;

  logic [2:0] c8m_sync_reg, br_sync_reg, bgack_sync_reg, as_sync_reg;
  logic       c8m_rise, c8m_fall, br_n_s, bgack_n_s, as_n_s;

  arb_state_t       state_reg, state_next;
  logic             bg_n_reg, bg_n_next;
  logic             br_seen_reg, br_seen_next;
  logic             arm_reg, arm_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] dma_count_reg, dma_count_next;
  logic             rec_done;
  logic             fair_block;

  // Strobes idle high after reset so nothing looks like a request while the chains fill.
  always_ff @(posedge PI_CLK or negedge SYS_RESET_n) begin
    if (!SYS_RESET_n) begin
      c8m_sync_reg   <= 3'b000;
      br_sync_reg    <= 3'b111;
      bgack_sync_reg <= 3'b111;
      as_sync_reg    <= 3'b111;
    end else begin
      c8m_sync_reg   <= {c8m_sync_reg[1:0], M68K_CLK};
      br_sync_reg    <= {br_sync_reg[1:0], M68K_BR_n};
      bgack_sync_reg <= {bgack_sync_reg[1:0], M68K_BGACK_n};
      as_sync_reg    <= {as_sync_reg[1:0], M68K_AS_n};
    end
  end

  assign c8m_rise  = c8m_sync_reg[1] & ~c8m_sync_reg[2];
  assign c8m_fall  = ~c8m_sync_reg[1] & c8m_sync_reg[2];
  assign br_n_s    = br_sync_reg[2];
  assign bgack_n_s = bgack_sync_reg[2];
  assign as_n_s    = as_sync_reg[2];

`ifdef ARB_FAIR_EN
  logic fair_block_reg;

  always_ff @(posedge PI_CLK or negedge SYS_RESET_n) begin
    if (!SYS_RESET_n) begin
      fair_block_reg <= 1'b0;
    end else if (rec_done && TXN_REQ) begin
      fair_block_reg <= 1'b1;
    end else if (TXN_DONE) begin
      fair_block_reg <= 1'b0;
    end
  end

  assign fair_block = fair_block_reg;
`else
  logic unused_fair;
  assign fair_block  = 1'b0;
  assign unused_fair = &{1'b0, TXN_REQ, TXN_DONE, rec_done};
`endif

  always_comb begin
    state_next     = state_reg;
    bg_n_next      = bg_n_reg;
    br_seen_next   = br_seen_reg;
    arm_next       = arm_reg;
    to_cnt_next    = to_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    dma_count_next = dma_count_reg;
    rec_done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bg_n_next    = 1'b1;
        to_cnt_next  = '0;
        gap_cnt_next = '0;
        if (arm_reg) begin
          // Qualified BR waits for the falling edge; recheck the bus is still free there.
          if (c8m_fall) begin
            arm_next = 1'b0;
            if (!TXN_ACTIVE && as_n_s) begin
              state_next = ST_GRANT;
              bg_n_next  = 1'b0;
            end else begin
              state_next = ST_PEND;
            end
          end
        end else if (c8m_rise) begin
          if (!bgack_n_s) begin
            state_next     = ST_OWNED;
            dma_count_next = dma_count_reg + 1'b1;
            br_seen_next   = 1'b0;
          end else if (!br_n_s && !fair_block) begin
            if (br_seen_reg) begin
              br_seen_next = 1'b0;
              if (!TXN_ACTIVE && as_n_s) begin
                arm_next = 1'b1;
              end else begin
                state_next = ST_PEND;
              end
            end else begin
              br_seen_next = 1'b1;
            end
          end else begin
            br_seen_next = 1'b0;
          end
        end
      end
      ST_PEND: begin
        br_seen_next = 1'b0;
        arm_next     = 1'b0;
        to_cnt_next  = '0;
        if (c8m_rise && br_n_s) begin
          state_next = ST_IDLE;
        end else if (c8m_fall && !TXN_ACTIVE && as_n_s) begin
          state_next = ST_GRANT;
          bg_n_next  = 1'b0;
        end
      end
      ST_GRANT: begin
        br_seen_next = 1'b0;
        arm_next     = 1'b0;
        if (c8m_rise) begin
          // BGACK is tested first so it wins over a coincident timeout.
          if (!bgack_n_s) begin
            state_next     = ST_OWNED;
            dma_count_next = dma_count_reg + 1'b1;
            to_cnt_next    = '0;
          end else if (br_n_s || (to_cnt_reg + 1'b1 == TO_LIMIT)) begin
            state_next  = ST_IDLE;
            bg_n_next   = 1'b1;
            to_cnt_next = '0;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
      end
      ST_OWNED: begin
        br_seen_next = 1'b0;
        arm_next     = 1'b0;
        if (c8m_rise) begin
          bg_n_next = 1'b1;
          if (bgack_n_s) begin
            state_next   = ST_RECOVER;
            gap_cnt_next = '0;
          end
        end
      end
      ST_RECOVER: begin
        br_seen_next = 1'b0;
        arm_next     = 1'b0;
        bg_n_next    = 1'b1;
        if (c8m_rise) begin
          if (gap_cnt_reg + 1'b1 == GAP_LIMIT) begin
            state_next   = ST_IDLE;
            gap_cnt_next = '0;
            rec_done     = 1'b1;
          end else begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        bg_n_next    = 1'b1;
        br_seen_next = 1'b0;
        arm_next     = 1'b0;
        to_cnt_next  = '0;
        gap_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge PI_CLK or negedge SYS_RESET_n) begin
    if (!SYS_RESET_n) begin
      state_reg     <= ST_IDLE;
      bg_n_reg      <= 1'b1;
      br_seen_reg   <= 1'b0;
      arm_reg       <= 1'b0;
      to_cnt_reg    <= '0;
      gap_cnt_reg   <= '0;
      dma_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bg_n_reg      <= bg_n_next;
      br_seen_reg   <= br_seen_next;
      arm_reg       <= arm_next;
      to_cnt_reg    <= to_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      dma_count_reg <= dma_count_next;
    end
  end

  // A pending idle-bus BR withholds the Pi grant so the DMA master is not starved.
  assign BUS_GRANT_PI = (state_reg == ST_IDLE) && bg_n_reg && bgack_n_s &&
                        !(!br_n_s && !TXN_ACTIVE && !fair_block);
  assign M68K_BG_n    = bg_n_reg;
  assign ARB_STATE    = state_reg;
  assign DMA_COUNT    = dma_count_reg;

endmodule

// File: tb/tb_pistorm_bus_arbiter.sv
// Directed bench for pistorm_bus_arbiter: grant latency, PEND, timeout, glitch rejection,
// async reset, foreign master and DMA/Pi interleaving (depends on ARB_FAIR_EN).
`timescale 1ns/100ps

module tb_pistorm_bus_arbiter;

  logic        PI_CLK, SYS_RESET_n, M68K_CLK;
  logic        man_br_n, man_bgack_n, man_as_n, man_active, TXN_REQ;
  logic        bgack_n, txn_active, txn_done;
  logic        BUS_GRANT_PI, M68K_BG_n;
  logic [2:0]  ARB_STATE;
  logic [15:0] DMA_COUNT;

  logic        eng_en, eng_active, eng_done;
  int          eng_cnt;
  logic        dma_en, dma_bgack;
  int          dma_cnt;

  int checks = 0;
  int passes = 0;

  assign bgack_n    = dma_en ? dma_bgack : man_bgack_n;
  assign txn_active = eng_en ? eng_active : man_active;
  assign txn_done   = eng_en & eng_done;

  pistorm_bus_arbiter #(.BG_TIMEOUT_CYC(16), .REARB_GAP_CYC(2), .CNT_W(16)) dut (
    .PI_CLK       (PI_CLK),
    .SYS_RESET_n  (SYS_RESET_n),
    .M68K_CLK     (M68K_CLK),
    .M68K_BR_n    (man_br_n),
    .M68K_BGACK_n (bgack_n),
    .M68K_AS_n    (man_as_n),
    .TXN_REQ      (TXN_REQ),
    .TXN_ACTIVE   (txn_active),
    .TXN_DONE     (txn_done),
    .BUS_GRANT_PI (BUS_GRANT_PI),
    .M68K_BG_n    (M68K_BG_n),
    .ARB_STATE    (ARB_STATE),
    .DMA_COUNT    (DMA_COUNT)
  );

  initial begin
    PI_CLK = 1'b0;
    forever #2.5 PI_CLK = ~PI_CLK;
  end

  // Offset keeps bus-clock edges clear of Pi-clock edges.
  initial begin
    M68K_CLK = 1'b0;
    #1.3;
    forever #62.5 M68K_CLK = ~M68K_CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pi transaction engine: starts a 20-cycle bus cycle whenever granted with a request pending.
  always @(negedge PI_CLK) begin
    eng_done <= 1'b0;
    if (!eng_en) begin
      eng_active <= 1'b0;
      eng_cnt    <= 0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_active <= 1'b0;
        eng_done   <= 1'b1;
      end
    end else if (BUS_GRANT_PI && TXN_REQ) begin
      eng_active <= 1'b1;
      eng_cnt    <= 20;
    end
  end

  // DMA master: acknowledges each grant and holds the bus for 100 Pi cycles.
  always @(negedge PI_CLK) begin
    if (!dma_en) begin
      dma_bgack <= 1'b1;
      dma_cnt   <= 0;
    end else if (dma_cnt != 0) begin
      dma_cnt <= dma_cnt - 1;
      if (dma_cnt == 1) dma_bgack <= 1'b1;
    end else if (!M68K_BG_n && dma_bgack) begin
      dma_bgack <= 1'b0;
      dma_cnt   <= 100;
    end
  end

  task automatic do_reset;
    SYS_RESET_n = 1'b0;
    man_br_n    = 1'b1;
    man_bgack_n = 1'b1;
    man_as_n    = 1'b1;
    man_active  = 1'b0;
    TXN_REQ     = 1'b0;
    eng_en      = 1'b0;
    dma_en      = 1'b0;
    repeat (4) @(negedge PI_CLK);
    SYS_RESET_n = 1'b1;
    repeat (4) @(negedge PI_CLK);
  endtask

  task automatic rise21;
    @(posedge M68K_CLK);
    #21;
  endtask

  task automatic wait_bg_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PI_CLK);
      if (!M68K_BG_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    SYS_RESET_n = 1'b0;
    man_br_n = 1'b1; man_bgack_n = 1'b1; man_as_n = 1'b1; man_active = 1'b0;
    TXN_REQ = 1'b0; eng_en = 1'b0; dma_en = 1'b0;
    repeat (3) @(negedge PI_CLK);
    checks++;
    if (M68K_BG_n !== 1'b1) $display("FAIL reset_bg_n: got %b expected 1", M68K_BG_n);
    else passes++;
    SYS_RESET_n = 1'b1;
    repeat (4) @(negedge PI_CLK);
    checks++;
    if (BUS_GRANT_PI !== 1'b1) $display("FAIL reset_grant_pi: got %b expected 1", BUS_GRANT_PI);
    else passes++;
    checks++;
    if (ARB_STATE !== 3'd0) $display("FAIL reset_state: got %0d expected 0", ARB_STATE);
    else passes++;
    checks++;
    if (DMA_COUNT !== 16'd0) $display("FAIL reset_dma_count: got %0d expected 0", DMA_COUNT);
    else passes++;
    $display("reset: bg_n=%b grant=%b state=%0d count=%0d", M68K_BG_n, BUS_GRANT_PI, ARB_STATE, DMA_COUNT);
  endtask

  task automatic test_basic_tenure;
    bit  ok;
    real t0, lat;
    do_reset();
    @(posedge M68K_CLK);
    #10;
    t0 = $realtime;
    man_br_n = 1'b0;
    wait_bg_low(ok);
    lat = $realtime - t0;
    checks++;
    if (!ok || lat < 250.0 || lat > 380.0)
      $display("FAIL grant_latency: got %0.1f ns (seen=%0d) expected 250..380 ns", lat, ok);
    else passes++;
    checks++;
    if (ARB_STATE !== 3'd2) $display("FAIL grant_state: got %0d expected 2", ARB_STATE);
    else passes++;
    #10;
    man_bgack_n = 1'b0;
    rise21();
    checks++;
    if (ARB_STATE !== 3'd3 || DMA_COUNT !== 16'd1)
      $display("FAIL owned_entry: got state %0d count %0d expected state 3 count 1", ARB_STATE, DMA_COUNT);
    else passes++;
    rise21();
    checks++;
    if (M68K_BG_n !== 1'b1) $display("FAIL owned_bg_negate: got %b expected 1", M68K_BG_n);
    else passes++;
    #9;
    man_bgack_n = 1'b1;
    man_br_n    = 1'b1;
    rise21();
    checks++;
    if (ARB_STATE !== 3'd4 || BUS_GRANT_PI !== 1'b0)
      $display("FAIL recover_entry: got state %0d grant %b expected state 4 grant 0", ARB_STATE, BUS_GRANT_PI);
    else passes++;
    rise21();
    checks++;
    if (BUS_GRANT_PI !== 1'b0) $display("FAIL recover_gap1: got grant %b expected 0", BUS_GRANT_PI);
    else passes++;
    rise21();
    checks++;
    if (ARB_STATE !== 3'd0 || BUS_GRANT_PI !== 1'b1 || DMA_COUNT !== 16'd1)
      $display("FAIL recover_exit: got state %0d grant %b count %0d expected 0 1 1",
               ARB_STATE, BUS_GRANT_PI, DMA_COUNT);
    else passes++;
    $display("basic tenure: latency %0.1f ns, count=%0d", lat, DMA_COUNT);
  endtask

  task automatic test_pend;
    do_reset();
    man_active = 1'b1;
    @(posedge M68K_CLK);
    #10;
    man_br_n = 1'b0;
    rise21();
    checks++;
    if (ARB_STATE !== 3'd0 || BUS_GRANT_PI !== 1'b1)
      $display("FAIL pend_first_sample: got state %0d grant %b expected 0 1", ARB_STATE, BUS_GRANT_PI);
    else passes++;
    rise21();
    checks++;
    if (ARB_STATE !== 3'd1) $display("FAIL pend_state: got %0d expected 1", ARB_STATE);
    else passes++;
    checks++;
    if (BUS_GRANT_PI !== 1'b0 || M68K_BG_n !== 1'b1)
      $display("FAIL pend_outputs: got grant %b bg_n %b expected 0 1", BUS_GRANT_PI, M68K_BG_n);
    else passes++;
    #10;
    man_active = 1'b0;
    @(negedge M68K_CLK);
    #21;
    checks++;
    if (M68K_BG_n !== 1'b0 || ARB_STATE !== 3'd2)
      $display("FAIL pend_to_grant: got bg_n %b state %0d expected 0 2", M68K_BG_n, ARB_STATE);
    else passes++;
    $display("pend: bg_n=%b state=%0d", M68K_BG_n, ARB_STATE);
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    do_reset();
    @(posedge M68K_CLK);
    #10;
    man_br_n = 1'b0;
    wait_bg_low(ok);
    n = 0;
    if (ok) begin
      for (int i = 0; i < 40; i++) begin
        rise21();
        n++;
        if (M68K_BG_n) break;
      end
    end
    checks++;
    if (!ok || n != 16) $display("FAIL timeout_rises: got %0d (grant seen=%0d) expected 16", n, ok);
    else passes++;
    checks++;
    if (ARB_STATE !== 3'd0 || M68K_BG_n !== 1'b1)
      $display("FAIL timeout_state: got state %0d bg_n %b expected 0 1", ARB_STATE, M68K_BG_n);
    else passes++;
    $display("timeout: BG withdrawn after %0d rises", n);
  endtask

  task automatic test_br_glitch;
    bit bad;
    do_reset();
    @(posedge M68K_CLK);
    #10;
    man_br_n = 1'b0;
    @(posedge M68K_CLK);
    #10;
    man_br_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge PI_CLK);
      if (!M68K_BG_n || ARB_STATE != 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL glitch_no_grant: got grant activity expected none");
    else passes++;
    checks++;
    if (ARB_STATE !== 3'd0 || BUS_GRANT_PI !== 1'b1)
      $display("FAIL glitch_idle: got state %0d grant %b expected 0 1", ARB_STATE, BUS_GRANT_PI);
    else passes++;
    $display("br glitch: state=%0d bg_n=%b", ARB_STATE, M68K_BG_n);
  endtask

  task automatic test_reset_mid_tenure;
    bit ok;
    do_reset();
    @(posedge M68K_CLK);
    #10;
    man_br_n = 1'b0;
    wait_bg_low(ok);
    #10;
    man_bgack_n = 1'b0;
    rise21();
    checks++;
    if (!ok || ARB_STATE !== 3'd3) $display("FAIL midreset_pre_owned: got state %0d expected 3", ARB_STATE);
    else passes++;
    #4;
    SYS_RESET_n = 1'b0;
    #1;
    checks++;
    if (M68K_BG_n !== 1'b1 || BUS_GRANT_PI !== 1'b1)
      $display("FAIL midreset_outputs: got bg_n %b grant %b expected 1 1", M68K_BG_n, BUS_GRANT_PI);
    else passes++;
    checks++;
    if (ARB_STATE !== 3'd0 || DMA_COUNT !== 16'd0)
      $display("FAIL midreset_state: got state %0d count %0d expected 0 0", ARB_STATE, DMA_COUNT);
    else passes++;
    $display("reset mid-tenure: bg_n=%b grant=%b state=%0d", M68K_BG_n, BUS_GRANT_PI, ARB_STATE);
  endtask

  task automatic test_foreign_master;
    do_reset();
    @(negedge M68K_CLK);
    #10;
    man_bgack_n = 1'b0;
    rise21();
    checks++;
    if (ARB_STATE !== 3'd3 || M68K_BG_n !== 1'b1)
      $display("FAIL foreign_owned: got state %0d bg_n %b expected 3 1", ARB_STATE, M68K_BG_n);
    else passes++;
    checks++;
    if (DMA_COUNT !== 16'd1 || BUS_GRANT_PI !== 1'b0)
      $display("FAIL foreign_count: got count %0d grant %b expected 1 0", DMA_COUNT, BUS_GRANT_PI);
    else passes++;
    $display("foreign master: state=%0d count=%0d", ARB_STATE, DMA_COUNT);
  endtask

  task automatic test_back_to_back;
    int dones, tenures, cyc, exp_dones;
    bit prev_owned, inv_bad;
`ifdef ARB_FAIR_EN
    exp_dones = 1;
`else
    exp_dones = 0;
`endif
    do_reset();
    eng_en   = 1'b1;
    dma_en   = 1'b1;
    TXN_REQ  = 1'b1;
    man_br_n = 1'b0;
    dones = 0; tenures = 0; cyc = 0; prev_owned = 1'b0; inv_bad = 1'b0;
    while (tenures < 3 && cyc < 20000) begin
      @(negedge PI_CLK);
      cyc++;
      if (txn_done) dones++;
      if (BUS_GRANT_PI && (!M68K_BG_n || !bgack_n)) inv_bad = 1'b1;
      if (ARB_STATE == 3'd3 && !prev_owned) begin
        if (tenures > 0) begin
          checks++;
          if (dones != exp_dones)
            $display("FAIL b2b_done_count: got %0d pi cycles before tenure %0d expected %0d", dones, tenures + 1, exp_dones);
          else passes++;
          $display("back-to-back: tenure %0d preceded by %0d pi cycles", tenures + 1, dones);
        end
        dones = 0;
        tenures++;
      end
      prev_owned = (ARB_STATE == 3'd3);
    end
    checks++;
    if (tenures != 3) $display("FAIL b2b_tenures: got %0d expected 3 within cycle budget", tenures);
    else passes++;
    checks++;
    if (inv_bad) $display("FAIL grant_invariant: got grant with BG/BGACK asserted expected never");
    else passes++;
    eng_en = 1'b0;
    dma_en = 1'b0;
  endtask

  initial begin
    eng_en = 1'b0;
    dma_en = 1'b0;
    test_reset();
    test_basic_tenure();
    test_pend();
    test_timeout();
    test_br_glitch();
    test_reset_mid_tenure();
    test_foreign_master();
    test_back_to_back();
    do_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
